// File: rtl/packConv.sv
// Shared FastConv datapath definitions: word type, multiplier phases
// and the multiplier-scheduler state encoding.
package packConv;

    localparam int NBITS = 16;
    localparam int HALF  = NBITS / 2;

    typedef logic [NBITS-1:0] regC;

    typedef enum logic [1:0] {
        ALBL,
        ALBH,
        AHBL,
        AHBH
    } mul_states;

    typedef enum logic [2:0] {
        IDLE,
        S_ALBL,
        S_ALBH,
        S_AHBL,
        S_AHBH,
        DONE
    } sched_states;

endpackage

// File: rtl/mult_iterate.sv
// Four-phase signed fixed-point multiplier: one half-by-half partial
// product per cycle, P = (A*B) >>> QUANT including the current phase.
module mult_iterate
    import packConv::*;
#(
    parameter int QUANT = 8
) (
    input  logic      clk,
    input  logic      reset,
    input  mul_states state,
    input  regC       a,
    input  regC       b,
    output regC       p
);

    localparam int AW = 2 * NBITS;
    localparam int PW = 2 * HALF + 2;

    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;
    logic signed [HALF:0] opx;
    logic signed [HALF:0] opy;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] term;

    // Low halves are unsigned, high halves carry the sign
    always_comb begin
        opx = {1'b0, a[HALF-1:0]};
        opy = {1'b0, b[HALF-1:0]};
        unique case (state)
            ALBL: begin
                opx = {1'b0, a[HALF-1:0]};
                opy = {1'b0, b[HALF-1:0]};
            end
            ALBH: begin
                opx = {1'b0, a[HALF-1:0]};
                opy = {b[NBITS-1], b[NBITS-1:HALF]};
            end
            AHBL: begin
                opx = {a[NBITS-1], a[NBITS-1:HALF]};
                opy = {1'b0, b[HALF-1:0]};
            end
            AHBH: begin
                opx = {a[NBITS-1], a[NBITS-1:HALF]};
                opy = {b[NBITS-1], b[NBITS-1:HALF]};
            end
            default: ;
        endcase
        prod = opx * opy;
        term = {{(AW-PW){prod[PW-1]}}, prod};
    end

    // ALBL restarts the sum; later phases add their weighted term
    always_comb begin
        acc_d = term;
        unique case (state)
            ALBL:       acc_d = term;
            ALBH, AHBL: acc_d = acc_q + (term <<< HALF);
            AHBH:       acc_d = acc_q + (term <<< (2 * HALF));
            default:    acc_d = term;
        endcase
        p = regC'(acc_d >>> QUANT);
    end

    // Partial-sum register
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from rr_ptr, pointer
// moves past the winner only when a grant is actually issued.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] rr_ptr_d;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] cand;
    logic [IDW:0]   sum;
    logic           hit;

    // First requester at or after the pointer, wrapping at NREQ
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        sum  = '0;
        cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            cand = sum[IDW-1:0];
            if (!hit && req[cand]) begin
                hit  = 1'b1;
                pick = cand;
            end
        end
    end

    // Grant vector and pointer advance
    always_comb begin
        gnt      = '0;
        gnt_id   = pick;
        rr_ptr_d = rr_ptr_q;
        if (en && hit) begin
            gnt[pick] = 1'b1;
            if (pick == IDW'(NREQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = pick + 1'b1;
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one mult_iterate among NREQ lanes.
// Optional MULT_SCHED_ZERO_SKIP_EN: zero operands finish in one cycle.
module mult_sched
    import packConv::*;
#(
    parameter  int NREQ  = 4,
    parameter  int QUANT = 8,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid,
    input  regC             req_a [NREQ],
    input  regC             req_b [NREQ],
    output logic [NREQ-1:0] req_ready,
    output logic            resp_valid,
    output logic [IDW-1:0]  resp_id,
    output regC             resp_p,
    output logic            busy
);

    sched_states    state_q;
    sched_states    state_d;
    regC            op_a_q;
    regC            op_a_d;
    regC            op_b_q;
    regC            op_b_d;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] id_d;
    logic           resp_valid_q;
    logic           resp_valid_d;
    logic [IDW-1:0] resp_id_q;
    logic [IDW-1:0] resp_id_d;
    regC            resp_p_q;
    regC            resp_p_d;

    logic           arb_en;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0] gnt_id;
    logic           accept;
    regC            sel_a;
    regC            sel_b;
    logic           zero_op;
    mul_states      mul_state;
    regC            mul_p;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    mult_iterate #(
        .QUANT (QUANT)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .state (mul_state),
        .a     (op_a_q),
        .b     (op_b_q),
        .p     (mul_p)
    );

    // Winner's operands and zero detection
    always_comb begin
        accept  = |gnt;
        sel_a   = req_a[gnt_id];
        sel_b   = req_b[gnt_id];
`ifdef MULT_SCHED_ZERO_SKIP_EN
        zero_op = (sel_a == '0) || (sel_b == '0);
`else
        zero_op = 1'b0;
`endif
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = zero_op ? DONE : S_ALBL;
                end else begin
                    state_d = IDLE;
                end
            end
            S_ALBL:  state_d = S_ALBH;
            S_ALBH:  state_d = S_AHBL;
            S_AHBL:  state_d = S_AHBH;
            S_AHBH:  state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decoded from state
    always_comb begin
        arb_en    = !reset && ((state_q == IDLE) || (state_q == DONE));
        req_ready = gnt;
        busy      = (state_q != IDLE);
        unique case (state_q)
            S_ALBL:  mul_state = ALBL;
            S_ALBH:  mul_state = ALBH;
            S_AHBL:  mul_state = AHBL;
            S_AHBH:  mul_state = AHBH;
            default: mul_state = ALBL;
        endcase
        resp_valid = resp_valid_q;
        resp_id    = resp_id_q;
        resp_p     = resp_p_q;
    end

    // Operand capture on accept, response capture entering DONE
    always_comb begin
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        id_d         = id_q;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_p_d     = resp_p_q;
        if (accept) begin
            op_a_d = sel_a;
            op_b_d = sel_b;
            id_d   = gnt_id;
        end
        if (state_q == S_AHBH) begin
            resp_valid_d = 1'b1;
            resp_id_d    = id_q;
            resp_p_d     = mul_p;
        end
        if (accept && zero_op) begin
            resp_valid_d = 1'b1;
            resp_id_d    = gnt_id;
            resp_p_d     = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a_q       <= '0;
            op_b_q       <= '0;
            id_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_p_q     <= '0;
        end else begin
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            id_q         <= id_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_p_q     <= resp_p_d;
        end
    end

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched: directed table, multi-cycle
// corner sequences and random traffic against a cycle-level model.
module tb_mult_sched;
    import packConv::*;

    localparam int N = 4;
    localparam int Q = 8;
`ifdef MULT_SCHED_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req_valid;
    regC          req_a [N];
    regC          req_b [N];
    logic [N-1:0] req_ready;
    logic         resp_valid;
    logic [1:0]   resp_id;
    regC          resp_p;
    logic         busy;

    mult_sched #(
        .NREQ  (N),
        .QUANT (Q)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_p     (resp_p),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    bit  m_have  = 0;
    int  m_due   = 0;
    int  m_id    = 0;
    regC m_p     = '0;
    int  m_ptr   = 0;
    regC last_p  = '0;
    int  last_id = 0;

    int  g_id [$];
    int  g_cyc [$];
    bit  seen_resp;
    int  resp_cyc;
    regC seen_p;
    int  seen_id;

    typedef struct {
        int  id;
        regC a;
        regC b;
        regC p;
    } vec_t;

    vec_t tv [7];

    function automatic regC ref_mul(regC a, regC b);
        longint pr;
        pr = longint'($signed(a)) * longint'($signed(b));
        pr = pr >>> Q;
        return regC'(pr);
    endfunction

    function automatic int rr_pick(logic [N-1:0] v, int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    endtask

    // One clock cycle: check outputs mid-cycle, advance model, step edge
    task automatic tick();
        logic [N-1:0] exp_rdy;
        int  pk;
        bit  win;
        bit  exp_v;
        bit  skip;
        #3;
        win = !m_have || (m_due == cyc);
        pk = rr_pick(req_valid, m_ptr);
        exp_rdy = '0;
        if (!reset && win && pk >= 0) exp_rdy[pk] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        exp_v = m_have && (m_due == cyc);
        if (exp_v) begin
            last_p  = m_p;
            last_id = m_id;
        end
        chk("resp_valid", 32'(resp_valid), 32'(exp_v));
        chk("resp_p", 32'(resp_p), 32'(last_p));
        chk("resp_id", 32'(resp_id), 32'(last_id));
        chk("busy", 32'(busy), 32'(m_have));
        if (resp_valid === 1'b1) begin
            seen_resp = 1;
            resp_cyc  = cyc;
            seen_p    = resp_p;
            seen_id   = int'(resp_id);
        end
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                if (req_ready[k] === 1'b1 && req_valid[k]) begin
                    g_id.push_back(k);
                    g_cyc.push_back(cyc);
                end
            end
        end
        if (reset) begin
            m_have  = 0;
            m_ptr   = 0;
            last_p  = '0;
            last_id = 0;
        end else begin
            if (exp_v) m_have = 0;
            if (exp_rdy != '0) begin
                skip   = ZS && (req_a[pk] == '0 || req_b[pk] == '0);
                m_have = 1;
                m_id   = pk;
                m_p    = skip ? regC'(0) : ref_mul(req_a[pk], req_b[pk]);
                m_due  = cyc + (skip ? 1 : 5);
                m_ptr  = (pk + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_grant(output int gc);
        int n0;
        gc = -1;
        for (int k = 0; k < 12 && gc < 0; k++) begin
            n0 = g_id.size();
            tick();
            if (g_id.size() > n0) gc = g_cyc[$];
        end
        chk("grant_timeout", 32'(gc >= 0), 32'd1);
    endtask

    task automatic run_idle(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int acc_c;
        int lat;
        int n3;
        int gsz;
        int gk;

        tv[0] = '{0, 16'h0200, 16'h0300, 16'h0600};
        tv[1] = '{2, 16'hFF00, 16'h0280, 16'hFD80};
        tv[2] = '{1, 16'h0100, 16'h0000, 16'h0000};
        tv[3] = '{3, 16'h8000, 16'h8000, 16'h0000};
        tv[4] = '{1, 16'h7FFF, 16'h7FFF, 16'hFF00};
        tv[5] = '{0, 16'hFFFF, 16'h0001, 16'hFFFF};
        tv[6] = '{2, 16'h0180, 16'h0180, 16'h0240};

        reset     = 1'b1;
        req_valid = '0;
        for (int k = 0; k < N; k++) begin
            req_a[k] = '0;
            req_b[k] = '0;
        end
        @(posedge clk);
        #1;
        do_reset();

        // Directed table
        for (int i = 0; i < 7; i++) begin
            req_a[tv[i].id] = tv[i].a;
            req_b[tv[i].id] = tv[i].b;
            req_valid = '0;
            req_valid[tv[i].id] = 1'b1;
            seen_resp = 0;
            wait_grant(acc_c);
            req_valid = '0;
            for (int k = 0; k < 10 && !seen_resp; k++) tick();
            chk("vec_resp_seen", 32'(seen_resp), 32'd1);
            chk("vec_p", 32'(seen_p), 32'(tv[i].p));
            chk("vec_id", 32'(seen_id), 32'(tv[i].id));
            lat = (ZS && (tv[i].a == '0 || tv[i].b == '0)) ? 1 : 5;
            chk("vec_latency", 32'(resp_cyc - acc_c), 32'(lat));
        end
        run_idle(2);

        // All four valid continuously
        do_reset();
        for (int k = 0; k < N; k++) begin
            req_a[k] = regC'($urandom_range(1, 16'hFFFF));
            req_b[k] = regC'($urandom_range(1, 16'hFFFF));
        end
        req_valid = '1;
        g_id.delete();
        g_cyc.delete();
        for (int c = 0; c < 26; c++) begin
            gsz = g_id.size();
            tick();
            if (g_id.size() > gsz) begin
                gk = g_id[$];
                req_a[gk] = regC'($urandom_range(1, 16'hFFFF));
                req_b[gk] = regC'($urandom_range(1, 16'hFFFF));
            end
        end
        req_valid = '0;
        chk("rr_grant_count", 32'(g_id.size() >= 5), 32'd1);
        for (int k = 0; k < 5 && k < g_id.size(); k++) begin
            chk("rr_order", 32'(g_id[k]), 32'(k % N));
            if (k > 0) chk("rr_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 32'd5);
        end
        run_idle(7);

        // Reset while in S_AHBL
        req_a[1]  = 16'h0300;
        req_b[1]  = 16'h0200;
        req_valid = 4'b0010;
        wait_grant(acc_c);
        req_valid = '0;
        run_idle(2);
        reset = 1'b1;
        seen_resp = 0;
        tick();
        reset = 1'b0;
        run_idle(6);
        chk("abort_no_resp", 32'(seen_resp), 32'd0);
        req_a[0]  = 16'h0100;
        req_b[0]  = 16'h0100;
        req_a[2]  = 16'h0100;
        req_b[2]  = 16'h0100;
        req_valid = 4'b0101;
        g_id.delete();
        g_cyc.delete();
        wait_grant(acc_c);
        req_valid = '0;
        chk("post_reset_gnt", 32'(g_id.size() > 0 ? g_id[0] : -1), 32'd0);
        run_idle(7);

        // Requester 3 drops before grant while 1 is busy
        req_a[1]  = 16'h0400;
        req_b[1]  = 16'h0040;
        req_a[3]  = 16'h0100;
        req_b[3]  = 16'h0200;
        req_valid = 4'b0010;
        g_id.delete();
        g_cyc.delete();
        wait_grant(acc_c);
        req_valid = 4'b1000;
        run_idle(2);
        req_valid = '0;
        run_idle(6);
        n3 = 0;
        foreach (g_id[k]) if (g_id[k] == 3) n3++;
        chk("drop_no_gnt3", 32'(n3), 32'd0);
        req_valid = 4'b1001;
        g_id.delete();
        g_cyc.delete();
        wait_grant(acc_c);
        req_valid = '0;
        chk("ptr_hold_gnt", 32'(g_id.size() > 0 ? g_id[0] : -1), 32'd3);
        run_idle(7);

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            gsz = g_id.size();
            tick();
            gk = (g_id.size() > gsz) ? g_id[$] : -1;
            for (int k = 0; k < N; k++) begin
                if (req_valid[k] && gk == k) begin
                    req_valid[k] = 1'b0;
                end else if (req_valid[k]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[k] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req_a[k] = ($urandom_range(0, 7) == 0) ? regC'(0)
                             : regC'($urandom);
                    req_b[k] = ($urandom_range(0, 7) == 0) ? regC'(0)
                             : regC'($urandom);
                    req_valid[k] = 1'b1;
                end
            end
            if (c == 200) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
        end
        req_valid = '0;
        run_idle(8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
